// File: rtl/pipeline_hazard_controller.sv
// Hazard controller for a 5-stage pipeline: resolves data-memory waits, taken
// branches and load-use hazards into stall/flush/redirect controls, with perf counters.
module pipeline_hazard_controller #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           reg_file_read_address_0_IF_ID,
    input  logic [4:0]           reg_file_read_address_1_IF_ID,
    input  logic                 rs0_used_IF_ID,
    input  logic                 rs1_used_IF_ID,
    input  logic                 mem_read_ID_EXE,
    input  logic [4:0]           reg_file_write_address_ID_EXE,
    input  logic                 branch_taken_EXE,
    input  logic                 data_mem_req_EX_MEM,
    input  logic                 data_mem_ready,
    input  logic                 clear_error,
    output logic                 stall_pc,
    output logic                 stall_IF_ID,
    output logic                 stall_ID_EXE,
    output logic                 stall_EX_MEM,
    output logic                 flush_IF_ID,
    output logic                 flush_ID_EXE,
    output logic                 flush_MEM_WB,
    output logic                 pc_redirect,
    output logic                 mem_timeout_error,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t               state_q, state_d;
    logic [WAIT_W-1:0]    wait_q, wait_d, wait_inc;
    logic                 err_q, err_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
    logic                 load_use, mem_wait;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign load_use = mem_read_ID_EXE && (reg_file_write_address_ID_EXE != 5'd0) &&
                      ((rs0_used_IF_ID && (reg_file_read_address_0_IF_ID == reg_file_write_address_ID_EXE)) ||
                       (rs1_used_IF_ID && (reg_file_read_address_1_IF_ID == reg_file_write_address_ID_EXE)));
    assign mem_wait = data_mem_req_EX_MEM && !data_mem_ready;
    assign wait_inc = wait_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        err_d        = err_q;
        stall_pc     = 1'b0;
        stall_IF_ID  = 1'b0;
        stall_ID_EXE = 1'b0;
        stall_EX_MEM = 1'b0;
        flush_IF_ID  = 1'b0;
        flush_ID_EXE = 1'b0;
        flush_MEM_WB = 1'b0;
        pc_redirect  = 1'b0;
        case (state_q)
            RUN, MEM_WAIT: begin
                if (mem_wait) begin
                    stall_pc     = 1'b1;
                    stall_IF_ID  = 1'b1;
                    stall_ID_EXE = 1'b1;
                    stall_EX_MEM = 1'b1;
                    flush_MEM_WB = 1'b1;
                    if (state_q == RUN) begin
                        state_d = MEM_WAIT;
                        wait_d  = '0;
                    end else begin
                        wait_d = wait_inc;
                        if (wait_inc == WAIT_W'(TIMEOUT_CYCLES)) begin
                            state_d = ERROR;
                            err_d   = 1'b1;
                        end
                    end
                end else begin
                    state_d = RUN;
                    // A taken branch flushes the decode slot, so any load-use there is moot.
                    if (branch_taken_EXE) begin
                        pc_redirect  = 1'b1;
                        flush_IF_ID  = 1'b1;
                        flush_ID_EXE = 1'b1;
                    end else if (load_use) begin
                        stall_pc     = 1'b1;
                        stall_IF_ID  = 1'b1;
                        flush_ID_EXE = 1'b1;
                    end
                end
            end
            ERROR: begin
                stall_pc     = 1'b1;
                stall_IF_ID  = 1'b1;
                stall_ID_EXE = 1'b1;
                stall_EX_MEM = 1'b1;
                if (clear_error) begin
                    state_d = RUN;
                    err_d   = 1'b0;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign stall_cnt_d = stall_pc     ? sat_inc(stall_cnt_q) : stall_cnt_q;
    assign flush_cnt_d = flush_ID_EXE ? sat_inc(flush_cnt_q) : flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wait_q      <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_timeout_error = err_q;
    assign stall_count       = stall_cnt_q;
    assign flush_count       = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: a rule-level model checked every
// cycle, plus hand-computed literal expectations for the key scenarios.
module tb_pipeline_hazard_controller;

    localparam int TMO = 4;
    localparam int CW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] rs0 = '0, rs1 = '0, rd = '0;
    logic rs0_used = 0, rs1_used = 0, mem_read = 0, branch = 0;
    logic req = 0, ready = 0, clr = 0;
    logic stall_pc, stall_IF_ID, stall_ID_EXE, stall_EX_MEM;
    logic flush_IF_ID, flush_ID_EXE, flush_MEM_WB, pc_redirect, mem_timeout_error;
    logic [CW-1:0] stall_count, flush_count;

    int total = 0;
    int bad   = 0;

    // model state: timeout flag, whether a wait is already in progress, wait length, counters
    bit m_err = 0, m_waiting = 0;
    int m_n = 0, m_sc = 0, m_fc = 0;

    pipeline_hazard_controller #(.TIMEOUT_CYCLES(TMO), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .reg_file_read_address_0_IF_ID(rs0), .reg_file_read_address_1_IF_ID(rs1),
        .rs0_used_IF_ID(rs0_used), .rs1_used_IF_ID(rs1_used),
        .mem_read_ID_EXE(mem_read), .reg_file_write_address_ID_EXE(rd),
        .branch_taken_EXE(branch), .data_mem_req_EX_MEM(req), .data_mem_ready(ready),
        .clear_error(clr),
        .stall_pc(stall_pc), .stall_IF_ID(stall_IF_ID), .stall_ID_EXE(stall_ID_EXE),
        .stall_EX_MEM(stall_EX_MEM), .flush_IF_ID(flush_IF_ID), .flush_ID_EXE(flush_ID_EXE),
        .flush_MEM_WB(flush_MEM_WB), .pc_redirect(pc_redirect),
        .mem_timeout_error(mem_timeout_error), .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Output vector order: stall_pc, stall_IF_ID, stall_ID_EXE, stall_EX_MEM,
    // flush_IF_ID, flush_ID_EXE, flush_MEM_WB, pc_redirect
    function automatic logic [7:0] expect_outs();
        bit wait_now, hazard;
        wait_now = req && !ready;
        hazard = mem_read && rd != 0 &&
                 ((rs0_used && rs0 == rd) || (rs1_used && rs1 == rd));
        if (m_err)          return 8'b1111_0000;
        else if (wait_now)  return 8'b1111_0010;
        else if (branch)    return 8'b0000_1101;
        else if (hazard)    return 8'b1100_0100;
        else                return 8'b0000_0000;
    endfunction

    function automatic logic [7:0] dut_outs();
        return {stall_pc, stall_IF_ID, stall_ID_EXE, stall_EX_MEM,
                flush_IF_ID, flush_ID_EXE, flush_MEM_WB, pc_redirect};
    endfunction

    initial begin : compare
        logic [7:0] e;
        forever begin
            @(negedge clk);
            e = expect_outs();
            if (rst_n) begin
                chk("outs", 32'(dut_outs()), 32'(e));
                chk("err_flag", 32'(mem_timeout_error), 32'(m_err));
                chk("stall_count", 32'(stall_count), 32'(m_sc));
                chk("flush_count", 32'(flush_count), 32'(m_fc));
            end else begin
                chk("rst_err_flag", 32'(mem_timeout_error), 32'd0);
                chk("rst_stall_count", 32'(stall_count), 32'd0);
                chk("rst_flush_count", 32'(flush_count), 32'd0);
            end
            @(posedge clk);
            if (!rst_n) begin
                m_err = 0; m_waiting = 0; m_n = 0; m_sc = 0; m_fc = 0;
            end else begin
                if (e[7]) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
                if (e[2]) m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
                if (m_err) begin
                    if (clr) m_err = 0;
                end else if (req && !ready) begin
                    // the entry cycle does not count; TMO further waiting cycles trip the error
                    if (m_waiting) begin
                        m_n++;
                        if (m_n == TMO) begin m_err = 1; m_waiting = 0; end
                    end else begin
                        m_waiting = 1; m_n = 0;
                    end
                end else begin
                    m_waiting = 0;
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs0 = 0; rs1 = 0; rd = 0; rs0_used = 0; rs1_used = 0;
        mem_read = 0; branch = 0; req = 0; ready = 0; clr = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        step(2);
        rst_n = 1;
    endtask

    task automatic load_use(input logic [4:0] r);
        mem_read = 1; rd = r; rs0 = r; rs0_used = 1;
    endtask

    initial begin : stim
        idle();
        step(2);
        chk("reset_outs", 32'(dut_outs()), 32'd0);
        chk("reset_cnt", 32'(stall_count), 32'd0);
        rst_n = 1;
        step(2);
        chk("idle_outs", 32'(dut_outs()), 32'd0);

        // single load-use bubble on rd=5
        load_use(5'd5);
        #1;
        chk("lu_outs", 32'(dut_outs()), 32'b1100_0100);
        step();
        idle();
        #1;
        chk("lu_stall_count", 32'(stall_count), 32'd1);
        chk("lu_gone", 32'(dut_outs()), 32'd0);

        // x0 never hazards; unused or mismatched sources do not either
        mem_read = 1; rd = 0; rs0 = 0; rs1 = 0; rs0_used = 1; rs1_used = 1;
        #1;
        chk("x0_no_hazard", 32'(dut_outs()), 32'd0);
        step();
        rd = 9; rs0 = 9; rs0_used = 0; rs1 = 3; rs1_used = 1;
        #1;
        chk("unused_src", 32'(dut_outs()), 32'd0);
        step();
        rs1 = 9;
        #1;
        chk("rs1_hazard", 32'(dut_outs()), 32'b1100_0100);
        step();
        idle();
        step();

        // branch overrides a coincident load-use on rd=7
        do_reset();
        load_use(5'd7); branch = 1;
        #1;
        chk("br_outs", 32'(dut_outs()), 32'b0000_1101);
        step();
        idle();
        #1;
        chk("br_flush_count", 32'(flush_count), 32'd1);
        chk("br_stall_count", 32'(stall_count), 32'd0);

        // 3 wait cycles then ready; the held branch redirects on the 4th
        do_reset();
        req = 1; ready = 0; branch = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mw_outs", 32'(dut_outs()), 32'b1111_0010);
            step();
        end
        ready = 1;
        #1;
        chk("mw_release_redirect", 32'(dut_outs()), 32'b0000_1101);
        step();
        idle();
        #1;
        chk("mw_stall_count", 32'(stall_count), 32'd3);
        step();

        // timeout: ready never rises
        do_reset();
        req = 1; ready = 0;
        step(TMO);
        chk("tmo_not_yet", 32'(mem_timeout_error), 32'd0);
        step();
        chk("tmo_flag", 32'(mem_timeout_error), 32'd1);
        req = 0;
        #1;
        chk("tmo_hold_stalls", 32'(dut_outs()), 32'b1111_0000);
        step(2);
        clr = 1;
        step();
        clr = 0;
        #1;
        chk("tmo_cleared", 32'(mem_timeout_error), 32'd0);
        chk("tmo_run_outs", 32'(dut_outs()), 32'd0);
        step();

        // counter saturation
        do_reset();
        load_use(5'd12);
        step(20);
        idle();
        #1;
        chk("sat_stall", 32'(stall_count), 32'd15);
        chk("sat_flush", 32'(flush_count), 32'd15);
        step();

        // async reset mid-wait
        do_reset();
        req = 1; ready = 0;
        step(2);
        rst_n = 0;
        #1;
        chk("async_rst_cnt", 32'(stall_count), 32'd0);
        idle();
        step();
        rst_n = 1;
        #1;
        chk("post_rst_outs", 32'(dut_outs()), 32'd0);
        step();

        // async reset out of ERROR
        req = 1; ready = 0;
        step(TMO + 2);
        chk("err_again", 32'(mem_timeout_error), 32'd1);
        rst_n = 0;
        #1;
        chk("err_async_rst", 32'(mem_timeout_error), 32'd0);
        idle();
        step();
        rst_n = 1;
        step(2);
        chk("err_rst_outs", 32'(dut_outs()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max consecutive data-memory wait cycles before error.
REQ-002 Parameter CNT_WIDTH, default 16, width of each performance counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 reg_file_read_address_0_IF_ID  input  5  rs0 of instruction in decode.
REQ-006 reg_file_read_address_1_IF_ID  input  5  rs1 of instruction in decode.
REQ-007 rs0_used_IF_ID / rs1_used_IF_ID  input  1 each  decoded instruction actually reads rs0 / rs1.
REQ-008 mem_read_ID_EXE  input  1  instruction in execute is a load.
REQ-009 reg_file_write_address_ID_EXE  input  5  rd of instruction in execute.
REQ-010 branch_taken_EXE  input  1  execute resolved a taken branch/jump.
REQ-011 data_mem_req_EX_MEM  input  1  memory stage has an outstanding load/store.
REQ-012 data_mem_ready  input  1  data memory completes the request this cycle.
REQ-013 clear_error  input  1  clears sticky timeout error.
REQ-014 stall_pc, stall_IF_ID, stall_ID_EXE, stall_EX_MEM  output  1 each  hold the corresponding register.
REQ-015 flush_IF_ID, flush_ID_EXE, flush_MEM_WB  output  1 each  load a bubble into the corresponding register.
REQ-016 pc_redirect  output  1  select branch target as next PC.
REQ-017 mem_timeout_error  output  1  sticky timeout flag.
REQ-018 stall_count, flush_count  output  CNT_WIDTH each  performance counters.

Function
REQ-019 FSM states SHALL be RUN, MEM_WAIT, ERROR; state, wait counter, error flag and perf counters are registered; stall/flush/redirect outputs are combinational from state and current inputs.
REQ-020 Load-use hazard SHALL be: mem_read_ID_EXE and rd_ID_EXE != 0 and ((rs0_used and rs0 == rd) or (rs1_used and rs1 == rd)).
REQ-021 Memory wait SHALL be: data_mem_req_EX_MEM and not data_mem_ready.
REQ-022 Priority SHALL be memory wait > taken branch > load-use; only the highest-priority condition drives outputs in a cycle.
REQ-023 Memory wait (RUN or MEM_WAIT): stall_pc, stall_IF_ID, stall_ID_EXE, stall_EX_MEM = 1, flush_MEM_WB = 1, all other outputs 0; branch and load-use are ignored and re-evaluated once the wait ends.
REQ-024 Taken branch without memory wait: pc_redirect, flush_IF_ID, flush_ID_EXE = 1, no stalls; a coincident load-use hazard is discarded (the decode instruction is flushed).
REQ-025 Load-use without branch or memory wait: stall_pc, stall_IF_ID, flush_ID_EXE = 1 for exactly that cycle (one bubble).
REQ-026 RUN -> MEM_WAIT on memory wait; MEM_WAIT -> RUN in the cycle data_mem_ready = 1 (outputs that cycle follow REQ-024/025 as in RUN).
REQ-027 Wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle with ready low; reaching TIMEOUT_CYCLES -> ERROR, mem_timeout_error = 1.
REQ-028 In ERROR all four stall outputs = 1, all flush/redirect outputs = 0; stays until clear_error = 1, then -> RUN with error flag cleared next edge.
REQ-029 stall_count SHALL increment each cycle stall_pc = 1; flush_count each cycle flush_ID_EXE = 1; both saturate at all-ones, never wrap.
REQ-030 Register x0 SHALL never create a load-use hazard.

Reset
REQ-031 rst_n low SHALL immediately force state RUN, wait counter 0, mem_timeout_error 0, stall_count 0, flush_count 0, independent of clk.
REQ-032 With no hazard inputs active, all stall, flush and redirect outputs SHALL be 0 out of reset.
REQ-033 Reset asserted mid-MEM_WAIT or in ERROR SHALL abort the wait and return to RUN without error.

Verification
REQ-034 Load rd=5 in EXE, decode rs0=5 used -> one cycle stall_pc=stall_IF_ID=flush_ID_EXE=1, stall_count=1.
REQ-035 Load rd=0, decode rs0=rs1=0 used -> no stall, no flush.
REQ-036 branch_taken_EXE=1 with coincident load-use on rd=7 -> pc_redirect=flush_IF_ID=flush_ID_EXE=1, stall_pc=0, flush_count=1.
REQ-037 data_mem_req=1, ready low 3 cycles then high -> 3 cycles all stalls + flush_MEM_WB, return to RUN on 4th; pending branch then redirects.
REQ-038 TIMEOUT_CYCLES=4, ready never rises -> mem_timeout_error=1 after 4 wait cycles, all stalls held; clear_error -> RUN, flag 0.
REQ-039 CNT_WIDTH=4, 20 load-use stalls -> stall_count saturates at 15.
